// File: rtl/lbist_ctrl.sv
// Logic BIST controller: drives LFSR patterns onto the CUT, folds the CUT
// responses into a MISR and compares the final signature against a golden
// value to produce a go/no-go verdict.
//
// start_i is a level request, not a pulse: holding it high starts a run and
// keeps it alive, dropping it aborts a run in progress, and a finished run
// is only re-armed after start_i has been seen low and then high again.
// response_i carries no valid strobe; it is sampled only in CAPTURE, one
// cycle after the pattern was presented in APPLY.
module lbist_ctrl #(
    parameter int unsigned NUM_PATTERNS = 1024,
    parameter logic [31:0] LFSR_SEED    = 32'hACE1_2468,
    parameter logic [31:0] MISR_SEED    = 32'h0000_0000,
    parameter logic [31:0] GOLDEN_SIG   = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        start_i,
    input  logic [31:0] response_i,
    output logic        test_mode_o,
    output logic [31:0] pattern_o,
    output logic        done_o,
    output logic        go_nogo_o,
    output logic [31:0] signature_o,
    output logic [2:0]  dbg_state
);

    localparam logic [31:0] POLY      = 32'h8020_0003;
    localparam logic [15:0] NUM_PAT16 = 16'(NUM_PATTERNS);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_INIT    = 3'd1,
        S_APPLY   = 3'd2,
        S_CAPTURE = 3'd3,
        S_COMPARE = 3'd4,
        S_DONE    = 3'd5
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [31:0] lfsr;
    logic [31:0] misr;
    logic [31:0] pat_q;
    logic [15:0] cnt;
    logic [15:0] cnt_inc;
    logic        pass;
    logic        seen_low;

    // One Galois step shared by the pattern generator and the signature register.
    function automatic logic [31:0] galois_step(input logic [31:0] v);
        return {v[30:0], 1'b0} ^ (v[31] ? POLY : 32'h0000_0000);
    endfunction

    assign cnt_inc = cnt + 16'd1;

    // State register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: any active state falls back to IDLE when start_i drops.
    // DONE waits for a low-then-high start_i and then launches the next run
    // directly, so the verdict stays visible until the new run begins.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:    if (start_i) state_next = S_INIT;
            S_INIT:    state_next = start_i ? S_APPLY : S_IDLE;
            S_APPLY:   state_next = start_i ? S_CAPTURE : S_IDLE;
            S_CAPTURE: begin
                if (!start_i) begin
                    state_next = S_IDLE;
                end else if (cnt_inc == NUM_PAT16) begin
                    state_next = S_COMPARE;
                end else begin
                    state_next = S_APPLY;
                end
            end
            S_COMPARE: state_next = start_i ? S_DONE : S_IDLE;
            S_DONE:    if (start_i && seen_low) state_next = S_INIT;
            default:   state_next = S_IDLE;
        endcase
    end

    // Datapath: seed in INIT, step LFSR/MISR in CAPTURE, latch verdict in COMPARE.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            lfsr     <= LFSR_SEED;
            misr     <= MISR_SEED;
            cnt      <= 16'd0;
            pass     <= 1'b0;
            pat_q    <= 32'h0000_0000;
            seen_low <= 1'b0;
        end else begin
            case (state)
                S_INIT: begin
                    lfsr <= LFSR_SEED;
                    misr <= MISR_SEED;
                    cnt  <= 16'd0;
                    pass <= 1'b0;
                end
                S_CAPTURE: begin
                    if (start_i) begin
                        lfsr <= galois_step(lfsr);
                        misr <= galois_step(misr) ^ response_i;
                        cnt  <= cnt_inc;
                    end
                end
                S_COMPARE: begin
                    if (start_i) pass <= (misr == GOLDEN_SIG);
                    seen_low <= 1'b0;
                end
                S_DONE: begin
                    if (!start_i) seen_low <= 1'b1;
                end
                default: ;
            endcase
            // pattern_o is registered so it only changes on entry to APPLY and
            // holds its value everywhere else.
            if (state_next == S_APPLY) begin
                pat_q <= (state == S_INIT) ? LFSR_SEED : galois_step(lfsr);
            end
        end
    end

    // Output decode.
    always_comb begin
        test_mode_o = (state == S_APPLY) || (state == S_CAPTURE);
        done_o      = (state == S_DONE);
        go_nogo_o   = (state == S_DONE) && pass;
        pattern_o   = pat_q;
        signature_o = misr;
        dbg_state   = state;
    end

endmodule
